// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the TrashbinCore bus bridge: address regions, IO map,
// FSM states and status bit positions.
package trashbin_bus_pkg;

  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_IO  = 4'hF;

  localparam logic [7:0] IO_LED    = 8'h00;
  localparam logic [7:0] IO_LEDG   = 8'h04;
  localparam logic [7:0] IO_HEX    = 8'h08;
  localparam logic [7:0] IO_CYCLES = 8'h0C;
  localparam logic [7:0] IO_STATUS = 8'h10;

  localparam int STATUS_BUS_ERROR_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    RESPOND
  } bus_state_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_IO,
    RGN_NONE
  } region_t;

  function automatic region_t decodeRegion(input logic [3:0] code);
    case (code)
      REGION_RAM: return RGN_RAM;
      REGION_IO:  return RGN_IO;
      default:    return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/trashbin_bus_bridge_if.sv
// Core data-port bus and TempRam port bundles. The core is master on the core
// bus; the bridge is master on the RAM bus.
interface trashbin_core_if;
  logic [31:0] AddressBus;
  logic [31:0] DataWriteBus;
  logic        WriteAssert;
  logic        ReadAssert;
  logic [31:0] DataReadBus;
  logic        ReadOK;
  logic        WriteOK;

  modport master (
    output AddressBus, DataWriteBus, WriteAssert, ReadAssert,
    input  DataReadBus, ReadOK, WriteOK
  );

  modport slave (
    input  AddressBus, DataWriteBus, WriteAssert, ReadAssert,
    output DataReadBus, ReadOK, WriteOK
  );
endinterface

interface trashbin_ram_if;
  logic [13:0] RamAddress;
  logic [31:0] RamWriteData;
  logic        RamWriteEnable;
  logic [31:0] RamReadData;

  modport master (
    output RamAddress, RamWriteData, RamWriteEnable,
    input  RamReadData
  );

  modport slave (
    input  RamAddress, RamWriteData, RamWriteEnable,
    output RamReadData
  );
endinterface

// File: rtl/trashbin_mmio_regs.sv
// MMIO register file: LED, green LED, hex display, free-running cycle counter
// and the sticky bus-error status, with write decode and read mux.
module trashbin_mmio_regs
  import trashbin_bus_pkg::*;
(
  input  logic        CoreClock,
  input  logic        ResetN,
  input  logic        wrEn,
  input  logic        setBusError,
  input  logic [7:0]  offset,
  input  logic [15:0] wrData,
  output logic [31:0] rdData,
  output logic [9:0]  LedReg,
  output logic [7:0]  LedGReg,
  output logic [15:0] HexReg,
  output logic        BusError
);

  logic [31:0] cycleCount;

  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      LedReg     <= '0;
      LedGReg    <= '0;
      HexReg     <= '0;
      cycleCount <= '0;
      BusError   <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (wrEn) begin
        case (offset)
          IO_LED:  LedReg  <= wrData[9:0];
          IO_LEDG: LedGReg <= wrData[7:0];
          IO_HEX:  HexReg  <= wrData[15:0];
          default: ;
        endcase
      end
      // A new unmapped access in the same cycle beats a software clear
      if (setBusError)
        BusError <= 1'b1;
      else if (wrEn && offset == IO_STATUS && wrData[STATUS_BUS_ERROR_BIT])
        BusError <= 1'b0;
    end
  end

  always_comb begin
    rdData = '0;
    case (offset)
      IO_LED:    rdData[9:0]  = LedReg;
      IO_LEDG:   rdData[7:0]  = LedGReg;
      IO_HEX:    rdData[15:0] = HexReg;
      IO_CYCLES: rdData       = cycleCount;
      IO_STATUS: rdData[STATUS_BUS_ERROR_BIT] = BusError;
      default:   rdData = '0;
    endcase
  end

endmodule

// File: rtl/trashbin_bus_bridge.sv
// TrashbinCore data-port bridge: decodes RAM / IO / unmapped regions, sequences
// the TempRam read latency and generates the ReadOK/WriteOK pulses.
//
// state    | meaning
// IDLE     | waiting for a request; the only state that accepts one
// RAM_WAIT | RAM read in flight, wait counter running down
// RESPOND  | OK pulse cycle; core drops its request, back to IDLE next edge
module trashbin_bus_bridge
  import trashbin_bus_pkg::*;
#(
  parameter int          RAM_READ_LATENCY    = 1,
  parameter logic [31:0] UNMAPPED_READ_VALUE = 32'hDEADBEEF
) (
  input  logic            CoreClock,
  input  logic            ResetN,
  trashbin_core_if.slave  coreBus,
  trashbin_ram_if.master  ramBus,
  output logic [9:0]      LedReg,
  output logic [7:0]      LedGReg,
  output logic [15:0]     HexReg,
  output logic            BusError
);

  localparam logic [1:0] WAIT_LOAD = 2'(RAM_READ_LATENCY);

  bus_state_t  state, stateNext;
  region_t     region;
  logic [1:0]  waitCnt;
  logic        acceptWrite, acceptRead, waitDone;
  logic        mmioWrite, mmioSetError;
  logic [31:0] mmioReadData;
  logic        unusedAddrBits;

  assign region         = decodeRegion(coreBus.AddressBus[31:28]);
  assign unusedAddrBits = ^{coreBus.AddressBus[27:16], coreBus.AddressBus[1:0]};

  always_comb begin
    stateNext   = state;
    acceptWrite = 1'b0;
    acceptRead  = 1'b0;
    waitDone    = 1'b0;
    case (state)
      IDLE: begin
        acceptWrite = coreBus.WriteAssert;
        acceptRead  = coreBus.ReadAssert && !coreBus.WriteAssert;
        if (acceptWrite)
          stateNext = RESPOND;
        else if (acceptRead)
          stateNext = (region == RGN_RAM) ? RAM_WAIT : RESPOND;
      end
      RAM_WAIT: begin
        // Counter reaches 0 on this edge: RAM data is valid now
        waitDone = (waitCnt == 2'd1);
        if (waitDone)
          stateNext = RESPOND;
      end
      RESPOND: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign mmioWrite    = acceptWrite && region == RGN_IO;
  assign mmioSetError = (acceptWrite || acceptRead) && region == RGN_NONE;

  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      waitCnt               <= '0;
      coreBus.ReadOK        <= 1'b0;
      coreBus.WriteOK       <= 1'b0;
      coreBus.DataReadBus   <= '0;
      ramBus.RamAddress     <= '0;
      ramBus.RamWriteData   <= '0;
      ramBus.RamWriteEnable <= 1'b0;
    end else begin
      coreBus.WriteOK       <= acceptWrite;
      coreBus.ReadOK        <= (acceptRead && region != RGN_RAM) || waitDone;
      ramBus.RamWriteEnable <= acceptWrite && region == RGN_RAM;
      if ((acceptWrite || acceptRead) && region == RGN_RAM)
        ramBus.RamAddress <= coreBus.AddressBus[15:2];
      if (acceptWrite && region == RGN_RAM)
        ramBus.RamWriteData <= coreBus.DataWriteBus;
      if (acceptRead) begin
        case (region)
          RGN_RAM: waitCnt             <= WAIT_LOAD;
          RGN_IO:  coreBus.DataReadBus <= mmioReadData;
          default: coreBus.DataReadBus <= UNMAPPED_READ_VALUE;
        endcase
      end else if (state == RAM_WAIT) begin
        waitCnt <= waitCnt - 2'd1;
        if (waitDone)
          coreBus.DataReadBus <= ramBus.RamReadData;
      end
    end
  end

  trashbin_mmio_regs uMmio (
    .CoreClock   (CoreClock),
    .ResetN      (ResetN),
    .wrEn        (mmioWrite),
    .setBusError (mmioSetError),
    .offset      (coreBus.AddressBus[7:0]),
    .wrData      (coreBus.DataWriteBus[15:0]),
    .rdData      (mmioReadData),
    .LedReg      (LedReg),
    .LedGReg     (LedGReg),
    .HexReg      (HexReg),
    .BusError    (BusError)
  );

endmodule

// File: tb/tb_trashbin_bus_bridge.sv
// Directed bench for trashbin_bus_bridge: instance A uses RAM latency 1,
// instance B uses latency 3; both see a behavioural TempRam model.
module tb_trashbin_bus_bridge;

  logic CoreClock = 1'b0;
  always #5 CoreClock = ~CoreClock;

  logic rstA, rstB;
  logic [9:0]  ledA, ledB;
  logic [7:0]  ledGA, ledGB;
  logic [15:0] hexA, hexB;
  logic        busErrA, busErrB;

  trashbin_core_if coreA ();
  trashbin_core_if coreB ();
  trashbin_ram_if  ramA ();
  trashbin_ram_if  ramB ();

  trashbin_bus_bridge #(.RAM_READ_LATENCY(1)) dutA (
    .CoreClock (CoreClock), .ResetN (rstA),
    .coreBus (coreA), .ramBus (ramA),
    .LedReg (ledA), .LedGReg (ledGA), .HexReg (hexA), .BusError (busErrA)
  );

  trashbin_bus_bridge #(.RAM_READ_LATENCY(3)) dutB (
    .CoreClock (CoreClock), .ResetN (rstB),
    .coreBus (coreB), .ramBus (ramB),
    .LedReg (ledB), .LedGReg (ledGB), .HexReg (hexB), .BusError (busErrB)
  );

  // TempRam model: data valid RAM_READ_LATENCY-1 edges after the bridge's address register
  logic [31:0] memA [0:16383];
  logic [31:0] memB [0:16383];
  logic [13:0] bAddr1, bAddr2;

  always @(posedge CoreClock) begin
    if (ramA.RamWriteEnable) memA[ramA.RamAddress] <= ramA.RamWriteData;
    if (ramB.RamWriteEnable) memB[ramB.RamAddress] <= ramB.RamWriteData;
    bAddr1 <= ramB.RamAddress;
    bAddr2 <= bAddr1;
  end
  assign ramA.RamReadData = memA[ramA.RamAddress];
  assign ramB.RamReadData = memB[bAddr2];

  int errCount;
  int checkCount;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdOk(input bit sel);
    return sel ? coreB.ReadOK : coreA.ReadOK;
  endfunction
  function automatic logic wrOk(input bit sel);
    return sel ? coreB.WriteOK : coreA.WriteOK;
  endfunction
  function automatic logic ramWe(input bit sel);
    return sel ? ramB.RamWriteEnable : ramA.RamWriteEnable;
  endfunction
  function automatic logic [13:0] ramAddr(input bit sel);
    return sel ? ramB.RamAddress : ramA.RamAddress;
  endfunction
  function automatic logic [31:0] rdData(input bit sel);
    return sel ? coreB.DataReadBus : coreA.DataReadBus;
  endfunction

  task automatic setReq(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                        input logic wr, input logic rd);
    if (sel) begin
      coreB.AddressBus = addr; coreB.DataWriteBus = data;
      coreB.WriteAssert = wr;  coreB.ReadAssert = rd;
    end else begin
      coreA.AddressBus = addr; coreA.DataWriteBus = data;
      coreA.WriteAssert = wr;  coreA.ReadAssert = rd;
    end
  endtask

  // lat = edges from accept to the cycle WriteOK is seen (0 = timeout); counts
  // include one trailing idle cycle to catch stretched pulses.
  task automatic busWrite(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                          input logic alsoRead, output int lat, output int okCount,
                          output int weCycles, output logic [13:0] weAddr, output int rdOkCount);
    lat = 0; okCount = 0; weCycles = 0; weAddr = '0; rdOkCount = 0;
    @(negedge CoreClock);
    setReq(sel, addr, data, 1'b1, alsoRead);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge CoreClock);
      if (ramWe(sel)) begin weCycles++; weAddr = ramAddr(sel); end
      if (rdOk(sel)) rdOkCount++;
      if (wrOk(sel)) begin okCount++; lat = i; end
    end
    setReq(sel, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CoreClock);
    if (ramWe(sel)) weCycles++;
    if (rdOk(sel)) rdOkCount++;
    if (wrOk(sel)) okCount++;
  endtask

  task automatic busRead(input bit sel, input logic [31:0] addr, output logic [31:0] data,
                         output int lat, output int okCount);
    lat = 0; okCount = 0; data = '0;
    @(negedge CoreClock);
    setReq(sel, addr, 32'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge CoreClock);
      if (rdOk(sel)) begin okCount++; lat = i; data = rdData(sel); end
    end
    setReq(sel, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CoreClock);
    if (rdOk(sel)) okCount++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, okCnt, weCyc, rdOkCnt, stray;
    logic [13:0] weAddr;
    logic [31:0] data, c1, c2;

    errCount = 0;
    checkCount = 0;
    rstA = 1'b0;
    rstB = 1'b0;
    setReq(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    setReq(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge CoreClock);

    checkValue("rst_readok",  {31'b0, coreA.ReadOK}, 32'h0);
    checkValue("rst_writeok", {31'b0, coreA.WriteOK}, 32'h0);
    checkValue("rst_ramwe",   {31'b0, ramA.RamWriteEnable}, 32'h0);
    checkValue("rst_buserr",  {31'b0, busErrA}, 32'h0);
    checkValue("rst_regs",    {ledGA, hexA, 8'h0}, 32'h0);
    checkValue("rst_led",     {22'b0, ledA}, 32'h0);
    checkValue("rst_rdata",   coreA.DataReadBus, 32'h0);
    rstA = 1'b1;
    rstB = 1'b1;

    // RAM write then read, latency 1
    busWrite(1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("ramwr_lat",   32'(lat), 32'd1);
    checkValue("ramwr_okcnt", 32'(okCnt), 32'd1);
    checkValue("ramwr_we",    32'(weCyc), 32'd1);
    checkValue("ramwr_addr",  {18'b0, weAddr}, 32'd4);
    busRead(1'b0, 32'h0000_0010, data, lat, okCnt);
    checkValue("ramrd_lat",   32'(lat), 32'd2);
    checkValue("ramrd_okcnt", 32'(okCnt), 32'd1);
    checkValue("ramrd_data",  data, 32'h1234_5678);

    // IO writes and read-back
    busWrite(1'b0, 32'hF000_0000, 32'h0000_03FF, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("led_lat", 32'(lat), 32'd1);
    checkValue("led_we",  32'(weCyc), 32'd0);
    checkValue("led_val", {22'b0, ledA}, 32'h3FF);
    busWrite(1'b0, 32'hF000_0008, 32'h1234_BEEF, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("hex_lat", 32'(lat), 32'd1);
    checkValue("hex_val", {16'b0, hexA}, 32'hBEEF);
    busWrite(1'b0, 32'hF000_0004, 32'h0000_01A5, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("ledg_val", {24'b0, ledGA}, 32'hA5);
    busRead(1'b0, 32'hF000_0004, data, lat, okCnt);
    checkValue("ledg_rd_lat", 32'(lat), 32'd1);
    checkValue("ledg_rd",     data, 32'h0000_00A5);
    busRead(1'b0, 32'hF000_0020, data, lat, okCnt);
    checkValue("io_unused_rd", data, 32'h0);
    checkValue("io_unused_err", {31'b0, busErrA}, 32'h0);

    // Cycle counter: accepts land 12 edges apart
    busRead(1'b0, 32'hF000_000C, c1, lat, okCnt);
    repeat (9) @(negedge CoreClock);
    busRead(1'b0, 32'hF000_000C, c2, lat, okCnt);
    checkValue("cycles_delta", c2, c1 + 32'd12);
    busWrite(1'b0, 32'hF000_000C, 32'h0, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("cycles_wr_ack", 32'(okCnt), 32'd1);

    // Unmapped access and write-1-to-clear
    busRead(1'b0, 32'h4000_0000, data, lat, okCnt);
    checkValue("unmap_rd",     data, 32'hDEAD_BEEF);
    checkValue("unmap_rd_lat", 32'(lat), 32'd1);
    checkValue("unmap_err",    {31'b0, busErrA}, 32'h1);
    busRead(1'b0, 32'hF000_0010, data, lat, okCnt);
    checkValue("status_rd",    data, 32'h1);
    busWrite(1'b0, 32'hF000_0010, 32'h1, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("status_clr",   {31'b0, busErrA}, 32'h0);
    busWrite(1'b0, 32'h2000_0040, 32'h5555_5555, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("unmap_wr_err", {31'b0, busErrA}, 32'h1);
    checkValue("unmap_wr_we",  32'(weCyc), 32'd0);
    checkValue("unmap_wr_lat", 32'(lat), 32'd1);
    busWrite(1'b0, 32'hF000_0010, 32'h1, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);

    // Simultaneous write and read: write wins
    busWrite(1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("both_lat",    32'(lat), 32'd1);
    checkValue("both_we",     32'(weCyc), 32'd1);
    checkValue("both_addr",   {18'b0, weAddr}, 32'd8);
    checkValue("both_rdok",   32'(rdOkCnt), 32'd0);
    busRead(1'b0, 32'h0000_0020, data, lat, okCnt);
    checkValue("both_rdback", data, 32'hCAFE_F00D);

    // Latency 3 instance
    busWrite(1'b1, 32'h0000_0100, 32'hA5A5_0001, 1'b0, lat, okCnt, weCyc, weAddr, rdOkCnt);
    checkValue("l3_wr_lat",  32'(lat), 32'd1);
    checkValue("l3_wr_addr", {18'b0, weAddr}, 32'd64);
    busRead(1'b1, 32'h0000_0100, data, lat, okCnt);
    checkValue("l3_rd_lat",   32'(lat), 32'd4);
    checkValue("l3_rd_okcnt", 32'(okCnt), 32'd1);
    checkValue("l3_rd_data",  data, 32'hA5A5_0001);

    // Reset while B is in RAM_WAIT
    @(negedge CoreClock);
    setReq(1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b1);
    @(negedge CoreClock);
    @(negedge CoreClock);
    rstB = 1'b0;
    #1;
    checkValue("midrst_readok", {31'b0, coreB.ReadOK}, 32'h0);
    checkValue("midrst_rdata",  coreB.DataReadBus, 32'h0);
    stray = 0;
    repeat (2) begin
      @(negedge CoreClock);
      if (rdOk(1'b1)) stray++;
    end
    setReq(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge CoreClock);
    rstB = 1'b1;
    repeat (6) begin
      @(negedge CoreClock);
      if (rdOk(1'b1)) stray++;
    end
    checkValue("midrst_no_ok", 32'(stray), 32'd0);
    busRead(1'b1, 32'h0000_0100, data, lat, okCnt);
    checkValue("postrst_lat",  32'(lat), 32'd4);
    checkValue("postrst_data", data, 32'hA5A5_0001);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
